skid_reg: RTL and testbench

Two-entry elastic pipeline register with a valid/ready handshake. It carries a stage's output to the next stage when the consumer controls the timing, instead of the producer. It replaces a plain enabled pipeline register where the downstream stage (e.g. a multi-cycle data memory or execute unit) must apply backpressure. It keeps full throughput, and every output, including the upstream `s_ready`, is driven from a flop, so no combinational ready path crosses the stage.

---
 rtl/skid_reg.sv | 145 ++++++++++++++
 tb/tb_skid_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/skid_reg.sv
// skid_reg: two-entry elastic pipeline register with a valid/ready handshake.
// The main register drives m_data and the skid register catches the one extra
// entry accepted while the consumer stalls. Every output, s_ready included,
// comes straight from a flop, so no combinational path crosses the stage.
module skid_reg #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         s_valid,
  input  logic [N-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [N-1:0] m_data,
  input  logic         m_ready,
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic         accept;
  logic         take;
  logic         ready_next;
  logic         valid_next;
  logic [1:0]   count_next;
  logic         load_main;
  logic         main_from_skid;
  logic         load_skid;
  logic [N-1:0] skid;

  // Handshake qualifiers, built only from registered outputs and inputs
  always_comb begin
    accept = s_valid & s_ready;
    take   = m_valid & m_ready;
  end

  // State register; the flags are registered copies decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      count   <= 2'd0;
    end else begin
      state   <= state_next;
      s_ready <= ready_next;
      m_valid <= valid_next;
      count   <= count_next;
    end
  end

  // Next-state selection; flush overrides any transfer in the same cycle
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) state_next = ONE;
        ONE: begin
          if (accept && !take)      state_next = FULL;
          else if (!accept && take) state_next = EMPTY;
        end
        FULL: if (take) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Output flags decoded from the next state so they can be registered alongside it
  always_comb begin
    ready_next = 1'b1;
    valid_next = 1'b0;
    count_next = 2'd0;
    unique case (state_next)
      EMPTY: begin
        ready_next = 1'b1;
        valid_next = 1'b0;
        count_next = 2'd0;
      end
      ONE: begin
        ready_next = 1'b1;
        valid_next = 1'b1;
        count_next = 2'd1;
      end
      FULL: begin
        ready_next = 1'b0;
        valid_next = 1'b1;
        count_next = 2'd2;
      end
      default: begin
        ready_next = 1'b1;
        valid_next = 1'b0;
        count_next = 2'd0;
      end
    endcase
  end

  // Datapath load enables; nothing loads on flush so m_data keeps its old value
  always_comb begin
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      unique case (state)
        EMPTY: load_main = accept;
        ONE: begin
          load_main = accept & take;
          load_skid = accept & ~take;
        end
        FULL: begin
          load_main      = take;
          main_from_skid = take;
        end
        default: ;
      endcase
    end
  end

  // Main register: head of the queue, refilled from upstream or from the skid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data <= '0;
    end else if (load_main) begin
      m_data <= main_from_skid ? skid : s_data;
    end
  end

  // Skid register: holds the second entry while the consumer stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid <= '0;
    end else if (load_skid) begin
      skid <= s_data;
    end
  end

endmodule

// File: tb/tb_skid_reg.sv
// tb_skid_reg: table-driven vectors for the skid_reg handshake plus a FIFO
// scoreboard that predicts every delivered entry and the occupancy flags.
module tb_skid_reg;

  localparam int unsigned N = 64;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         s_valid;
  logic [N-1:0] s_data;
  logic         s_ready;
  logic         m_valid;
  logic [N-1:0] m_data;
  logic         m_ready;
  logic [1:0]   count;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] mdata_model;

  typedef struct {
    logic         sv;
    logic [N-1:0] sd;
    logic         mr;
    logic         fl;
    logic         e_mv;
    logic [1:0]   e_cnt;
    logic         e_rdy;
    logic [N-1:0] e_md;
  } vec_t;

  vec_t vecs[$];

  skid_reg #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic sv, input logic [N-1:0] sd, input logic mr,
                              input logic fl, input logic mv, input logic [1:0] cnt,
                              input logic rdy, input logic [N-1:0] md);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.fl = fl;
    v.e_mv = mv; v.e_cnt = cnt; v.e_rdy = rdy; v.e_md = md;
    return v;
  endfunction

  // One clock of stimulus; the scoreboard predicts the transfer and checks the result
  task automatic step(input logic sv, input logic [N-1:0] sd, input logic mr, input logic fl);
    bit acc;
    bit tk;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    acc = sv && (exp_q.size() < 2);
    tk  = mr && (exp_q.size() > 0);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (tk) begin
        chk("sb_take_data", m_data, exp_q.pop_front());
      end
      if (acc) exp_q.push_back(sd);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) mdata_model = exp_q[0];
    chk("sb_count",   {62'd0, count},   N'(exp_q.size()));
    chk("sb_m_valid", {63'd0, m_valid}, {63'd0, exp_q.size() > 0});
    chk("sb_s_ready", {63'd0, s_ready}, {63'd0, exp_q.size() < 2});
    chk("sb_m_data",  m_data, mdata_model);
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      step(vecs[i].sv, vecs[i].sd, vecs[i].mr, vecs[i].fl);
      chk($sformatf("vec%0d_m_valid", i), {63'd0, m_valid}, {63'd0, vecs[i].e_mv});
      chk($sformatf("vec%0d_count", i),   {62'd0, count},   {62'd0, vecs[i].e_cnt});
      chk($sformatf("vec%0d_s_ready", i), {63'd0, s_ready}, {63'd0, vecs[i].e_rdy});
      chk($sformatf("vec%0d_m_data", i),  m_data,           vecs[i].e_md);
    end
    vecs.delete();
  endtask

  initial begin
    reset   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    mdata_model = '0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_count",   {62'd0, count},   64'd0);
    chk("rst_m_data",  m_data,           64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single transfer
    vecs.push_back(mk(1, 64'hAA, 1, 0, 1, 1, 1, 64'hAA));
    vecs.push_back(mk(0, 64'h0,  1, 0, 0, 0, 1, 64'hAA));
    // Streaming 0x1..0x8
    for (int unsigned k = 1; k <= 8; k++)
      vecs.push_back(mk(1, N'(k), 1, 0, 1, 1, 1, N'(k)));
    vecs.push_back(mk(0, 64'h0,  1, 0, 0, 0, 1, 64'h8));
    // Backpressure and fill, then drain
    vecs.push_back(mk(1, 64'h10, 0, 0, 1, 1, 1, 64'h10));
    vecs.push_back(mk(1, 64'h11, 0, 0, 1, 2, 0, 64'h10));
    vecs.push_back(mk(1, 64'h12, 0, 0, 1, 2, 0, 64'h10));
    vecs.push_back(mk(1, 64'h12, 1, 0, 1, 1, 1, 64'h11));
    vecs.push_back(mk(1, 64'h12, 1, 0, 1, 1, 1, 64'h12));
    vecs.push_back(mk(0, 64'h0,  1, 0, 0, 0, 1, 64'h12));
    // Simultaneous accept and take in ONE
    vecs.push_back(mk(1, 64'h20, 0, 0, 1, 1, 1, 64'h20));
    vecs.push_back(mk(1, 64'h21, 1, 0, 1, 1, 1, 64'h21));
    vecs.push_back(mk(0, 64'h0,  1, 0, 0, 0, 1, 64'h21));
    // Flush from FULL with a same-cycle accept attempt
    vecs.push_back(mk(1, 64'h30, 0, 0, 1, 1, 1, 64'h30));
    vecs.push_back(mk(1, 64'h31, 0, 0, 1, 2, 0, 64'h30));
    vecs.push_back(mk(1, 64'h32, 1, 1, 0, 0, 1, 64'h30));
    vecs.push_back(mk(0, 64'h0,  1, 0, 0, 0, 1, 64'h30));
    // Flush from ONE discards the same-cycle accept
    vecs.push_back(mk(1, 64'h40, 0, 0, 1, 1, 1, 64'h40));
    vecs.push_back(mk(1, 64'h41, 0, 1, 0, 0, 1, 64'h40));
    vecs.push_back(mk(0, 64'h0,  1, 0, 0, 0, 1, 64'h40));
    run_vecs();

    // Reset mid-operation: fill, then drop reset between edges
    step(1, 64'h50, 0, 0);
    step(1, 64'h51, 0, 0);
    chk("pre_rst_count", {62'd0, count}, 64'd2);
    @(negedge clk);
    s_valid = 1'b0;
    reset = 1'b0;
    #1;
    exp_q.delete();
    mdata_model = '0;
    chk("async_rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("async_rst_count",   {62'd0, count},   64'd0);
    chk("async_rst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("async_rst_m_data",  m_data,           64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    vecs.push_back(mk(1, 64'h60, 0, 0, 1, 1, 1, 64'h60));
    vecs.push_back(mk(0, 64'h0,  1, 0, 0, 0, 1, 64'h60));
    run_vecs();

    // Randomised traffic checked only by the scoreboard
    for (int unsigned k = 0; k < 200; k++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
